// File: rtl/matrix_alu_if.sv
// Request/response bundle between the matrix memory read path and the matrix execution stage.
// The master drives the operands and start; the slave returns busy, done and the result.
interface matrix_alu_if #(
  parameter int ELEM_W = 16,
  parameter int DIM    = 4
);
  localparam int BUS_W = ELEM_W * DIM * DIM;

  logic             start;
  logic [1:0]       opcode;
  logic [BUS_W-1:0] op_a;
  logic [BUS_W-1:0] op_b;
  logic             busy;
  logic             done;
  logic [BUS_W-1:0] result;

  modport master (output start, opcode, op_a, op_b, input busy, done, result);
  modport slave  (input start, opcode, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/matrix_alu.sv
// Matrix execution stage: 4x4 add/sub/transpose in one cycle, multiply one element per cycle.
// All arithmetic wraps modulo 2^ELEM_W; result only changes on the edge that pulses done.
module matrix_alu #(
  parameter int ELEM_W = 16,
  parameter int DIM    = 4
) (
  input  logic         clk,
  input  logic         nReset,
  matrix_alu_if.slave  bus
);
  localparam int BUS_W = ELEM_W * DIM * DIM;
  localparam int CW    = $clog2(DIM * DIM);
  localparam logic [CW-1:0] LAST_IDX = CW'(DIM * DIM - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_TRP = 2'b11;

  typedef enum logic {IDLE, COMPUTE} state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [BUS_W-1:0] r_a;
  logic [BUS_W-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic [BUS_W-1:0] r_scratch;
  logic [BUS_W-1:0] r_result;
  logic             r_busy;
  logic             r_done;

  logic [BUS_W-1:0]         w_ew;
  logic signed [ELEM_W-1:0] w_mac;
  logic [BUS_W-1:0]         w_scr_nxt;

  function automatic logic signed [ELEM_W-1:0] elem(input logic [BUS_W-1:0] m,
                                                    input int r, input int c);
    return $signed(m[ELEM_W*(DIM*r+c) +: ELEM_W]);
  endfunction

  function automatic logic signed [ELEM_W-1:0] add_wrap(input logic signed [ELEM_W-1:0] x,
                                                        input logic signed [ELEM_W-1:0] y);
    return x + y;
  endfunction

  function automatic logic signed [ELEM_W-1:0] sub_wrap(input logic signed [ELEM_W-1:0] x,
                                                        input logic signed [ELEM_W-1:0] y);
    return x - y;
  endfunction

  // Dot product of row r of A with column c of B; only the low ELEM_W bits survive.
  function automatic logic signed [ELEM_W-1:0] mac_elem(input logic [BUS_W-1:0] a,
                                                        input logic [BUS_W-1:0] b,
                                                        input int r, input int c);
    logic signed [ELEM_W-1:0]   acc;
    logic signed [2*ELEM_W-1:0] prod;
    acc = '0;
    for (int k = 0; k < DIM; k++) begin
      prod = elem(a, r, k) * elem(b, k, c);
      acc  = acc + $signed(prod[ELEM_W-1:0]);
    end
    return acc;
  endfunction

  always_comb begin
    w_ew = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        case (r_op)
          OP_ADD:  w_ew[ELEM_W*(DIM*r+c) +: ELEM_W] = add_wrap(elem(r_a, r, c), elem(r_b, r, c));
          OP_SUB:  w_ew[ELEM_W*(DIM*r+c) +: ELEM_W] = sub_wrap(elem(r_a, r, c), elem(r_b, r, c));
          OP_TRP:  w_ew[ELEM_W*(DIM*r+c) +: ELEM_W] = elem(r_a, c, r);
          default: w_ew[ELEM_W*(DIM*r+c) +: ELEM_W] = '0;
        endcase
      end
    end
  end

  always_comb begin
    w_mac     = mac_elem(r_a, r_b, int'(r_cnt) / DIM, int'(r_cnt) % DIM);
    w_scr_nxt = r_scratch;
    w_scr_nxt[ELEM_W*r_cnt +: ELEM_W] = w_mac;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_scratch <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op    <= bus.opcode;
            r_a     <= bus.op_a;
            r_b     <= bus.op_b;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (r_op != OP_MUL) begin
            r_result <= w_ew;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else begin
            // The final element goes straight into result alongside the scratch copy.
            r_scratch <= w_scr_nxt;
            r_cnt     <= r_cnt + 1'b1;
            if (r_cnt == LAST_IDX) begin
              r_result <= w_scr_nxt;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
endmodule

// File: tb/tb_matrix_alu.sv
// Directed self-checking bench for matrix_alu: arithmetic wrap, transpose, multiply timing,
// asynchronous reset mid-operation and start handshake corner cases.
module tb_matrix_alu;
  localparam int BW = 256;

  logic clk;
  logic nReset;
  int   checks;
  int   errors;

  matrix_alu_if bus ();

  matrix_alu dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] fill(input logic [15:0] v);
    logic [BW-1:0] m;
    for (int i = 0; i < 16; i++) m[16*i +: 16] = v;
    return m;
  endfunction

  function automatic logic [BW-1:0] ramp(input logic [15:0] base);
    logic [BW-1:0] m;
    for (int i = 0; i < 16; i++) m[16*i +: 16] = base + 16'(i);
    return m;
  endfunction

  function automatic logic [BW-1:0] ident();
    logic [BW-1:0] m;
    for (int i = 0; i < 16; i++) m[16*i +: 16] = (i % 5 == 0) ? 16'h0001 : 16'h0000;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.op_a   = a;
    bus.op_b   = b;
    tick();
    bus.start  = 1'b0;
  endtask

  // busy and done must never be high together
  always @(negedge clk) begin
    if (nReset === 1'b1) begin
      checks++;
      if (bus.busy === 1'b1 && bus.done === 1'b1) begin
        errors++;
        $display("FAIL busy_done_overlap got busy=%b done=%b want not both 1", bus.busy, bus.done);
      end
    end
  end

  task automatic test_reset();
    nReset     = 1'b0;
    bus.start  = 1'b0;
    bus.opcode = 2'b00;
    bus.op_a   = '0;
    bus.op_b   = '0;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.result !== '0) begin
      errors++;
      $display("FAIL reset_result got %h want 0", bus.result);
    end
    nReset = 1'b1;
    tick();
  endtask

  task automatic test_add();
    launch(2'b00, fill(16'h7FFF), fill(16'h0001));
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL add_accept got busy=%b done=%b want 1 0", bus.busy, bus.done);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL add_done got busy=%b done=%b want 0 1", bus.busy, bus.done);
    end
    checks++;
    if (bus.result !== fill(16'h8000)) begin
      errors++;
      $display("FAIL add_overflow got %h want %h", bus.result, fill(16'h8000));
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.result !== fill(16'h8000)) begin
      errors++;
      $display("FAIL add_hold got done=%b result=%h want done=0 result=%h", bus.done, bus.result, fill(16'h8000));
    end
  endtask

  task automatic test_sub();
    launch(2'b01, fill(16'h0000), fill(16'h0001));
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.result !== fill(16'hFFFF)) begin
      errors++;
      $display("FAIL sub_wrap got done=%b result=%h want done=1 result=%h", bus.done, bus.result, fill(16'hFFFF));
    end
  endtask

  task automatic test_transpose();
    logic [15:0]   tv [16];
    logic [BW-1:0] exp_m;
    tv = '{16'd0, 16'd4, 16'd8, 16'd12, 16'd1, 16'd5, 16'd9, 16'd13,
           16'd2, 16'd6, 16'd10, 16'd14, 16'd3, 16'd7, 16'd11, 16'd15};
    for (int i = 0; i < 16; i++) exp_m[16*i +: 16] = tv[i];
    launch(2'b11, ramp(16'h0000), fill(16'hAAAA));
    tick();
    checks++;
    if (bus.result[16*1 +: 16] !== 16'h0004) begin
      errors++;
      $display("FAIL trp_r0c1 got %h want 0004", bus.result[16*1 +: 16]);
    end
    checks++;
    if (bus.result[16*14 +: 16] !== 16'h000B) begin
      errors++;
      $display("FAIL trp_r3c2 got %h want 000b", bus.result[16*14 +: 16]);
    end
    checks++;
    if (bus.result !== exp_m || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL trp_full got done=%b result=%h want done=1 result=%h", bus.done, bus.result, exp_m);
    end
  endtask

  task automatic test_mul_identity();
    logic [BW-1:0] prev;
    prev = bus.result;
    launch(2'b10, ident(), ramp(16'h0001));
    for (int e = 1; e < 16; e++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.result !== prev) begin
        errors++;
        $display("FAIL mul_wait edge %0d got busy=%b done=%b result=%h want 1 0 %h",
                 e, bus.busy, bus.done, bus.result, prev);
      end
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.result !== ramp(16'h0001)) begin
      errors++;
      $display("FAIL mul_ident got busy=%b done=%b result=%h want 0 1 %h",
               bus.busy, bus.done, bus.result, ramp(16'h0001));
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mul_done_pulse got done=%b want 0", bus.done);
    end
  endtask

  task automatic test_mul_values();
    logic [BW-1:0] av [3];
    logic [BW-1:0] bv [3];
    logic [BW-1:0] ev [3];
    av = '{fill(16'h0100), fill(16'h0002), fill(16'hFFFF)};
    bv = '{fill(16'h0100), fill(16'h0003), fill(16'h0003)};
    ev = '{fill(16'h0000), fill(16'h0018), fill(16'hFFF4)};
    for (int t = 0; t < 3; t++) begin
      launch(2'b10, av[t], bv[t]);
      repeat (16) tick();
      checks++;
      if (bus.done !== 1'b1 || bus.result !== ev[t]) begin
        errors++;
        $display("FAIL mul_val %0d got done=%b result=%h want done=1 result=%h", t, bus.done, bus.result, ev[t]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    launch(2'b10, ident(), ramp(16'h0001));
    repeat (8) tick();
    nReset = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b result=%h want 0 0 0", bus.busy, bus.done, bus.result);
    end
    #3;
    nReset = 1'b1;
    seen_done = 1'b0;
    repeat (20) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort got activity=%b want 0", seen_done);
    end
    launch(2'b00, fill(16'h0001), fill(16'h0002));
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.result !== fill(16'h0003)) begin
      errors++;
      $display("FAIL reset_recover got done=%b result=%h want done=1 result=%h", bus.done, bus.result, fill(16'h0003));
    end
  endtask

  task automatic test_start_while_busy();
    launch(2'b10, ident(), ramp(16'h0001));
    bus.start  = 1'b1;
    bus.opcode = 2'b00;
    bus.op_a   = fill(16'h0002);
    bus.op_b   = fill(16'h0003);
    repeat (15) tick();
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.result !== ramp(16'h0001)) begin
      errors++;
      $display("FAIL busy_ignore got done=%b result=%h want done=1 result=%h", bus.done, bus.result, ramp(16'h0001));
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_second got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    bus.start  = 1'b1;
    bus.opcode = 2'b00;
    bus.op_a   = fill(16'h0001);
    bus.op_b   = fill(16'h0002);
    tick();
    bus.opcode = 2'b01;
    bus.op_a   = fill(16'h0005);
    bus.op_b   = fill(16'h0007);
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.result !== fill(16'h0003)) begin
      errors++;
      $display("FAIL b2b_first got done=%b result=%h want done=1 result=%h", bus.done, bus.result, fill(16'h0003));
    end
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.result !== fill(16'h0003)) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b done=%b result=%h want 1 0 %h", bus.busy, bus.done, bus.result, fill(16'h0003));
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.result !== fill(16'hFFFE)) begin
      errors++;
      $display("FAIL b2b_second got done=%b result=%h want done=1 result=%h", bus.done, bus.result, fill(16'hFFFE));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_transpose();
    test_mul_identity();
    test_mul_values();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
